spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the far end of the link driven by our SPI controller.
//  Samples the controller's DCLK/CS/COPI asynchronously, oversampled on the system clock.
//  Delivers each received word with a one-cycle valid pulse. Returns a word from a one-entry TX holding buffer on CIPO.
// PARAMETERS
//  DATA_WIDTH   8  bits per word (>=2)
//  SYNC_STAGES  2  flip-flop depth of each input synchronizer (>=2)
// PORTS
//  clk_in            in   1           system clock (100 MHz)
//  rst_n_in          in   1           asynchronous, active-low reset
//  tx_data_in        in   DATA_WIDTH  word to return on the next transfer
//  tx_valid_in       in   1           tx_data_in offered
//  tx_ready_out      out  1           holding buffer empty; write accepted when tx_valid_in & tx_ready_out
//  data_out          out  DATA_WIDTH  last complete received word
//  data_valid_out    out  1           one-cycle pulse: data_out updated
//  underrun_out      out  1           one-cycle pulse: word started with empty buffer (zeros sent)
//  frame_error_out   out  1           one-cycle pulse: CS rose mid-word
//  busy_out          out  1           high while in ACTIVE
//  chip_clk_in       in   1           DCLK from controller (async)
//  chip_sel_in       in   1           CS, active low (async)
//  chip_data_in      in   1           COPI (async)
//  chip_data_out     out  1           CIPO
//  chip_data_oe_out  out  1           CIPO output enable (= CS low, synchronized)
// BEHAVIOUR
//  Reset (rst_n_in=0, async):
//  - All outputs 0, buffer empty, bit counter 0, state WAIT_DESELECT.
//  - tx_ready_out rises on the first clk_in edge after release.
//  Sync/edges: DCLK, CS and COPI each pass SYNC_STAGES flops.
//  - Edges are detected by comparing the synchronized value with its previous registered value.
//  - All actions happen one cycle after detection: SYNC_STAGES+1 clk_in edges after the pin change.
//  - Requirement: DCLK half-period >= SYNC_STAGES+2 clk_in cycles.
//  FSM:
//  - WAIT_DESELECT -> IDLE when synced CS=1. Guards against reset released mid-frame.
//  - IDLE -> ACTIVE on synced CS fall:
//    - load shift_tx from buffer if full (buffer emptied), else load 0 and pulse underrun_out;
//    - bit_cnt=0; drive MSB on CIPO.
//  - ACTIVE, DCLK rise: shift_rx <= {shift_rx[W-2:0], COPI}; bit_cnt++.
//    - At bit_cnt==W-1: data_out <= the completed word; pulse data_valid_out; bit_cnt <= 0; set reload flag.
//  - ACTIVE, DCLK fall:
//    - if reload flag: load shift_tx from buffer, with the same underrun rule; clear flag;
//    - else shift_tx <<= 1.
//    - CIPO = shift_tx MSB at all times in ACTIVE.
//  - ACTIVE -> IDLE on synced CS rise:
//    - bit_cnt==0: clean end, no pulse;
//    - else pulse frame_error_out, discard the partial RX word and the TX word in flight.
//    - Pending reload is cancelled; the buffer is untouched.
//  - DCLK edges in IDLE/WAIT_DESELECT are ignored. CIPO=0 and oe=0 outside ACTIVE.
//  Buffer:
//  - tx_ready_out is registered: 0 when full, and stays 0 until the cycle after consumption.
//  - A write in the same cycle as an empty-buffer consumption fills the buffer for the next word; the current word is zeros.
//  Multi-word frames:
//  - Words continue back-to-back while CS stays low.
//  - Each word boundary consumes the buffer at the following DCLK fall.
//  Simultaneous CS rise and DCLK edge in one cycle: CS wins, and the edge is ignored.
// TESTING
//  - Drive pins on clk_in negedge, DCLK half-period 50 cycles.
//  Scenarios:
//  1. Load 0xA5, controller sends 0x3C -> CIPO bits 1,0,1,0,0,1,0,1; data_out=0x3C with one data_valid_out pulse; no errors.
//  2. Empty buffer, controller sends 0xFF -> underrun_out pulse at CS fall; CIPO all 0; data_out=0xFF.
//  3. CS low for 16 DCLKs, buffer 0x12 then 0x34 written after the first accept -> CIPO returns 0x12,0x34; two data_valid_out pulses, each with the correct word.
//  4. CS rises after 5 DCLK rises -> frame_error_out pulse; no data_valid_out; the next full frame is received correctly.
//  5. Assert rst_n_in after 3 bits with CS held low -> outputs 0 immediately; DCLK edges ignored until CS high, then a clean frame works.
//  6. Write with buffer full -> tx_ready_out=0; the second word is not accepted and the first word is transmitted.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder. DCLK, CS and COPI are synchronized into clk_in and their edges drive a
// two-process FSM. A one-entry holding buffer supplies the word returned on CIPO.
module spi_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  underrun_out,
  output logic                  frame_error_out,
  output logic                  busy_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  output logic                  chip_data_oe_out
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_WAIT_DESELECT = 2'd0,
    ST_IDLE          = 2'd1,
    ST_ACTIVE        = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] dclk_sync, cs_sync, copi_sync;
  logic                   dclk_prev, cs_prev;
  logic                   dclk_s, cs_s, copi_s;
  logic                   dclk_rise, dclk_fall, cs_rise, cs_fall;

  logic [DATA_WIDTH-1:0]  shift_tx, shift_rx, buf_data;
  logic                   buf_full, reload;
  logic [CW-1:0]          bit_cnt;

  logic start_frame, end_frame, load_tx, shift_tx_en, rx_shift, word_done, frame_err;
  logic wr_acc;

  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];

  assign dclk_rise = dclk_s & ~dclk_prev;
  assign dclk_fall = ~dclk_s & dclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dclk_sync <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      dclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], chip_clk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_sel_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], chip_data_in};
      dclk_prev <= dclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_WAIT_DESELECT;
    else           state <= state_next;
  end

  // CS rise is checked first so that a DCLK edge landing in the same cycle is dropped.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    load_tx     = 1'b0;
    shift_tx_en = 1'b0;
    rx_shift    = 1'b0;
    word_done   = 1'b0;
    frame_err   = 1'b0;
    case (state)
      ST_WAIT_DESELECT: begin
        if (cs_s) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_next  = ST_ACTIVE;
          start_frame = 1'b1;
          load_tx     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          end_frame  = 1'b1;
          frame_err  = (bit_cnt != '0);
        end else if (dclk_rise) begin
          rx_shift  = 1'b1;
          word_done = (bit_cnt == LAST_BIT);
        end else if (dclk_fall) begin
          if (reload) load_tx = 1'b1;
          else        shift_tx_en = 1'b1;
        end
      end
      default: state_next = ST_WAIT_DESELECT;
    endcase
  end

  // Handshake: a word is written when tx_valid_in & tx_ready_out at a clk_in edge; tx_ready_out
  // is registered, drops with the write and returns one cycle after the buffer is consumed.
  assign wr_acc = tx_valid_in & tx_ready_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      buf_full        <= 1'b0;
      buf_data        <= '0;
      tx_ready_out    <= 1'b0;
      shift_tx        <= '0;
      shift_rx        <= '0;
      bit_cnt         <= '0;
      reload          <= 1'b0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      underrun_out    <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      tx_ready_out    <= ~(buf_full | wr_acc);
      data_valid_out  <= word_done;
      underrun_out    <= load_tx & ~buf_full;
      frame_error_out <= frame_err;

      if (wr_acc) begin
        buf_full <= 1'b1;
        buf_data <= tx_data_in;
      end else if (load_tx) begin
        buf_full <= 1'b0;
      end

      if (load_tx)          shift_tx <= buf_full ? buf_data : '0;
      else if (shift_tx_en) shift_tx <= shift_tx << 1;

      if (start_frame || end_frame) begin
        bit_cnt  <= '0;
        reload   <= 1'b0;
        shift_rx <= '0;
      end else if (rx_shift) begin
        shift_rx <= {shift_rx[DATA_WIDTH-2:0], copi_s};
        if (word_done) begin
          data_out <= {shift_rx[DATA_WIDTH-2:0], copi_s};
          bit_cnt  <= '0;
          reload   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (load_tx) begin
        reload <= 1'b0;
      end
    end
  end

  assign busy_out         = (state == ST_ACTIVE);
  assign chip_data_oe_out = busy_out;
  assign chip_data_out    = busy_out & shift_tx[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: drives a mode-0 controller on clk_in negedges and checks against a
// word-level model of the holding buffer, received words and error pulses.
module tb_spi_peripheral;
  localparam int W    = 8;
  localparam int HALF = 50;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b1;
  logic [W-1:0] tx_data_in = '0;
  logic         tx_valid_in = 1'b0;
  logic         tx_ready_out;
  logic [W-1:0] data_out;
  logic         data_valid_out, underrun_out, frame_error_out, busy_out;
  logic         chip_clk_in = 1'b0;
  logic         chip_sel_in = 1'b1;
  logic         chip_data_in = 1'b0;
  logic         chip_data_out, chip_data_oe_out;

  spi_peripheral #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .tx_data_in       (tx_data_in),
    .tx_valid_in      (tx_valid_in),
    .tx_ready_out     (tx_ready_out),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .underrun_out     (underrun_out),
    .frame_error_out  (frame_error_out),
    .busy_out         (busy_out),
    .chip_clk_in      (chip_clk_in),
    .chip_sel_in      (chip_sel_in),
    .chip_data_in     (chip_data_in),
    .chip_data_out    (chip_data_out),
    .chip_data_oe_out (chip_data_oe_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int exp_ur = 0, got_ur = 0, exp_fe = 0, got_fe = 0;

  // model of the holding buffer
  bit           m_full = 1'b0;
  logic [W-1:0] m_buf  = '0;

  always @(negedge clk_in) begin
    if (data_valid_out)  got_q.push_back(data_out);
    if (underrun_out)    got_ur++;
    if (frame_error_out) got_fe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic consume(output logic [W-1:0] w);
    if (m_full) begin
      w      = m_buf;
      m_full = 1'b0;
    end else begin
      w = '0;
      exp_ur++;
    end
  endtask

  // driver tasks
  task automatic tx_write(input logic [W-1:0] d);
    @(negedge clk_in);
    check("tx_ready", {31'd0, tx_ready_out}, {31'd0, !m_full});
    tx_data_in  = d;
    tx_valid_in = 1'b1;
    @(negedge clk_in);
    tx_valid_in = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = d;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {24'd0, data_out}, 32'd0);
    check({tag, "_pulses"}, {29'd0, data_valid_out, underrun_out, frame_error_out}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_out}, 32'd0);
    check({tag, "_cipo"},  {30'd0, chip_data_out, chip_data_oe_out}, 32'd0);
    check({tag, "_ready"}, {31'd0, tx_ready_out}, 32'd0);
  endtask

  task automatic check_end(input string tag);
    logic [W-1:0] g, e;
    wait_cycles(HALF);
    check({tag, "_nvalid"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, {24'd0, g}, {24'd0, e});
    end
    exp_q.delete();
    got_q.delete();
    check({tag, "_underruns"}, got_ur, exp_ur);
    check({tag, "_frame_errs"}, got_fe, exp_fe);
    check({tag, "_idle"}, {29'd0, busy_out, chip_data_oe_out, chip_data_out}, 32'd0);
  endtask

  // One CS-low frame of nbits DCLK periods. COPI bit j is pat[15-j]. A buffer write is made in
  // the low phase before rise wr_bit (if >= 0). The last DCLK fall either coincides with the
  // CS rise (sep_end=0) or comes half a period before it (sep_end=1).
  task automatic run_frame(input string tag, input int nbits, input bit sep_end,
                           input int wr_bit, input logic [W-1:0] wr_data, input logic [15:0] pat);
    logic [W-1:0] tx_w;
    logic [W-1:0] rx_acc;
    int           idx;
    rx_acc = '0;
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    consume(tx_w);
    for (int j = 0; j < nbits; j++) begin
      chip_data_in = pat[15-j];
      rx_acc = {rx_acc[W-2:0], pat[15-j]};
      if (j == wr_bit) begin
        wait_cycles(10);
        tx_write(wr_data);
        wait_cycles(HALF - 12);
      end else begin
        wait_cycles(HALF);
      end
      idx = W - 1 - (j % W);
      check({tag, "_cipo"}, {31'd0, chip_data_out}, {31'd0, tx_w[idx]});
      check({tag, "_active"}, {30'd0, busy_out, chip_data_oe_out}, 32'd3);
      chip_clk_in = 1'b1;
      if (j % W == W - 1) exp_q.push_back(rx_acc);
      wait_cycles(HALF);
      chip_clk_in = 1'b0;
      if (j == nbits - 1) begin
        if (sep_end) begin
          if (j % W == W - 1) consume(tx_w);
          wait_cycles(HALF);
        end
        chip_sel_in = 1'b1;
      end else if (j % W == W - 1) begin
        consume(tx_w);
      end
    end
    if (nbits % W != 0) exp_fe++;
    check_end(tag);
  endtask

  int           nb, wb;
  bit           sep;
  logic [W-1:0] tw;

  initial begin
    rst_n_in = 1'b0;
    #1;
    check_outputs_zero("reset");
    wait_cycles(3);
    rst_n_in = 1'b1;
    check("ready_before_edge", {31'd0, tx_ready_out}, 32'd0);
    @(posedge clk_in);
    #1;
    check("ready_after_release", {31'd0, tx_ready_out}, 32'd1);
    wait_cycles(10);

    // basic transfer with a loaded buffer
    tx_write(8'hA5);
    run_frame("s1", 8, 1'b0, -1, 8'h00, 16'h3C00);
    check("s1_data_out", {24'd0, data_out}, 32'h3C);

    // empty buffer: zeros returned, underrun at CS fall
    run_frame("s2", 8, 1'b0, -1, 8'h00, 16'hFF00);
    check("s2_data_out", {24'd0, data_out}, 32'hFF);

    // two back-to-back words, second buffered during the first
    tx_write(8'h12);
    run_frame("s3", 16, 1'b0, 2, 8'h34, 16'hC3_5E);

    // aborted word, then a clean one
    run_frame("s4_abort", 5, 1'b0, -1, 8'h00, 16'hF800);
    run_frame("s4_clean", 8, 1'b0, -1, 8'h00, 16'h9600);

    // reset mid-frame with CS held low
    tx_write(8'h77);
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    chip_data_in = 1'b1;
    consume(tw);
    for (int j = 0; j < 3; j++) begin
      wait_cycles(HALF);
      chip_clk_in = 1'b1;
      wait_cycles(HALF);
      chip_clk_in = 1'b0;
    end
    wait_cycles(10);
    rst_n_in = 1'b0;
    #1;
    check_outputs_zero("s5_reset");
    m_full = 1'b0;
    wait_cycles(3);
    rst_n_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_cycles(HALF);
      chip_clk_in = ~chip_clk_in;
      wait_cycles(5);
      check("s5_ignored", {29'd0, busy_out, chip_data_oe_out, data_valid_out}, 32'd0);
    end
    chip_sel_in = 1'b1;
    check_end("s5_deselect");
    tx_write(8'hC9);
    run_frame("s5_clean", 8, 1'b0, -1, 8'h00, 16'h5A00);

    // write while full is refused
    tx_write(8'h11);
    tx_write(8'h22);
    run_frame("s6", 8, 1'b0, -1, 8'h00, 16'h0F00);

    // last DCLK fall before CS rise consumes the buffer at the word boundary
    run_frame("s7", 8, 1'b1, -1, 8'h00, 16'hE100);

    // randomized frames
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) tx_write(W'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tx_write(W'($urandom_range(0, 255)));
      nb  = $urandom_range(1, 16);
      sep = 1'($urandom_range(0, 1));
      wb  = $urandom_range(0, nb);
      if (wb == nb) wb = -1;
      run_frame("rand", nb, sep, wb, W'($urandom_range(0, 255)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
